// File: rtl/ramarb.sv
// Two-requester round-robin arbiter in front of a shared single-port RAM with asynchronous read.
// Define RAMARB_CLEAR_EN to zero the whole RAM after every reset before accepting requests.
module ramarb #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic          b_valid,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [AW-1:0] a_addr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] a_din,
    input  logic [DW-1:0] b_din,
    output logic          a_ready,
    output logic          b_ready,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    logic          run;
    logic          clearing;
    logic [AW-1:0] clr_addr;

`ifdef RAMARB_CLEAR_EN
    typedef enum logic {
        S_RUN,
        S_CLEAR
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] clr_reg, clr_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_CLEAR;
            clr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            clr_reg   <= clr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        clr_next   = clr_reg;
        if (state_reg == S_CLEAR) begin
            clr_next = clr_reg + 1'b1;
            if (clr_reg == {AW{1'b1}}) begin
                state_next = S_RUN;
            end
        end
    end

    assign run      = (state_reg == S_RUN) && !rst;
    assign clearing = (state_reg == S_CLEAR) && !rst;
    assign clr_addr = clr_reg;
`else
    assign run      = !rst;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = clearing;

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]    we_v;
    logic [1:0]    fire;
    logic [1:0]    rvalid_v;
    logic [DW-1:0] rdata_v [2];
    logic          ptr_reg, ptr_next;

    assign we_v = {b_we, a_we};

    // When both are valid the pointer breaks the tie; otherwise the lone requester wins.
    assign fire[0] = run && a_valid && (!b_valid || !ptr_reg);
    assign fire[1] = run && b_valid && (!a_valid || ptr_reg);

    assign a_ready = fire[0];
    assign b_ready = fire[1];

    always_comb begin
        ptr_next = ptr_reg;
        if (fire[0]) begin
            ptr_next = 1'b1;
        end else if (fire[1]) begin
            ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (clearing) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
        end else if (fire[0]) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_din  = a_we ? a_din : '0;
        end else if (fire[1]) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_din  = b_we ? b_din : '0;
        end
    end

    // Per-requester read-return registers; outputs are forced to zero while reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic          rvalid_reg;
            logic [DW-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= fire[gi] && !we_v[gi];
                    if (fire[gi] && !we_v[gi]) begin
                        rdata_reg <= ram_dout;
                    end
                end
            end

            assign rvalid_v[gi] = rvalid_reg && !rst;
            assign rdata_v[gi]  = rst ? '0 : rdata_reg;
        end
    endgenerate

    assign a_rvalid = rvalid_v[0];
    assign b_rvalid = rvalid_v[1];
    assign a_rdata  = rdata_v[0];
    assign b_rdata  = rdata_v[1];

endmodule

// File: tb/tb_ramarb.sv
// Bench for ramarb: directed vector table, clear/reset sequences and randomized traffic
// compared against a transaction-level model of arbitration and memory contents.
module tb_ramarb;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_valid, b_valid, a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic          a_ready, b_ready, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ramarb #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .b_valid(b_valid), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_din(a_din), .b_din(b_din),
        .a_ready(a_ready), .b_ready(b_ready), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy)
    );

    // Shared RAM: asynchronous read, synchronous write.
    logic [DW-1:0] ram_mem [DEPTH];
    assign ram_dout = ram_mem[ram_addr];
    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
    end

    // Reference model: expected memory image, tie-break pointer and returned read data.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_ptr;
    logic          m_arv, m_brv;
    logic [DW-1:0] m_ard, m_brd;
    int            p_w;
    logic          p_ar, p_br, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_din;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic aw, input int aa, input int ad,
                         input logic bv, input logic bw, input int ba, input int bd);
        rst = r; a_valid = av; a_we = aw; a_addr = AW'(aa); a_din = DW'(ad);
        b_valid = bv; b_we = bw; b_addr = AW'(ba); b_din = DW'(bd);
    endtask

    task automatic predict();
        if (rst) p_w = -1;
        else if (a_valid && b_valid) p_w = m_ptr;
        else if (a_valid) p_w = 0;
        else if (b_valid) p_w = 1;
        else p_w = -1;
        p_ar   = (p_w == 0);
        p_br   = (p_w == 1);
        p_we   = (p_w == 0) ? a_we : (p_w == 1) ? b_we : 1'b0;
        p_addr = (p_w == 0) ? a_addr : (p_w == 1) ? b_addr : '0;
        p_din  = !p_we ? '0 : (p_w == 0) ? a_din : b_din;
    endtask

    task automatic model_edge();
        if (rst) begin
            m_ptr = 0; m_arv = 0; m_brv = 0; m_ard = '0; m_brd = '0;
        end else begin
            m_arv = 0; m_brv = 0;
            if (p_w == 0) begin
                if (a_we) m_mem[a_addr] = a_din;
                else begin m_ard = m_mem[a_addr]; m_arv = 1; end
                m_ptr = 1;
            end else if (p_w == 1) begin
                if (b_we) m_mem[b_addr] = b_din;
                else begin m_brd = m_mem[b_addr]; m_brv = 1; end
                m_ptr = 0;
            end
        end
    endtask

    task automatic check_model();
        predict();
        chk("a_ready", a_ready, p_ar);
        chk("b_ready", b_ready, p_br);
        chk("ram_we", ram_we, p_we);
        chk("ram_addr", ram_addr, p_addr);
        if (p_we) chk("ram_din", ram_din, p_din);
        chk("a_rvalid", a_rvalid, rst ? 1'b0 : m_arv);
        chk("a_rdata", a_rdata, rst ? '0 : m_ard);
        chk("b_rvalid", b_rvalid, rst ? 1'b0 : m_brv);
        chk("b_rdata", b_rdata, rst ? '0 : m_brd);
        chk("busy", busy, 1'b0);
    endtask

    task automatic finish_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        drive(1, 1, 0, 1, 0, 1, 0, 2, 0);
        #4;
        check_model();
        $display("[TB] reset cycle");
        finish_cycle();
    endtask

    // Clear walk after reset release: exactly n zero-writes at ascending addresses.
    task automatic clear_seq(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, $urandom_range(0, DEPTH-1), 0, 1, 1, $urandom_range(0, DEPTH-1), 7);
            #4;
            chk("clr_busy", busy, 1'b1);
            chk("clr_ready", {a_ready, b_ready}, 2'b00);
            chk("clr_we", ram_we, 1'b1);
            chk("clr_addr", ram_addr, AW'(i));
            chk("clr_din", ram_din, '0);
            m_mem[i] = '0;
            @(posedge clk);
            #1;
        end
        $display("[TB] clear walk of %0d cycles", n);
    endtask

    typedef struct {
        int unsigned r, av, aw, aa, ad, bv, bw, ba, bd;
        int unsigned ear, ebr, ewe, eaddr, edin, earv, eard, ebrv, ebrd;
    } vec_t;

    vec_t tab [23];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RAMARB_CLEAR_EN
            ram_mem[i] = DW'(32'hA5A50000 + i * 3 + 1);
`else
            ram_mem[i] = '0;
`endif
            m_mem[i] = ram_mem[i];
        end
        m_ptr = 0; m_arv = 0; m_brv = 0; m_ard = '0; m_brd = '0; p_w = -1;

        //        r av aw aa  ad            bv bw ba  bd           ar br we addr din           arv ard           brv brd
        tab[0]  = '{1, 0, 0, 0,  0,            0, 0, 0,  0,           0, 0, 0, 0,  0,            0, 0,            0, 0};
        tab[1]  = '{0, 1, 1, 5,  32'hDEADBEEF, 0, 0, 0,  0,           1, 0, 1, 5,  32'hDEADBEEF, 0, 0,            0, 0};
        tab[2]  = '{0, 1, 0, 5,  0,            0, 0, 0,  0,           1, 0, 0, 5,  0,            0, 0,            0, 0};
        tab[3]  = '{0, 1, 0, 5,  0,            1, 0, 6,  0,           0, 1, 0, 6,  0,            1, 32'hDEADBEEF, 0, 0};
        tab[4]  = '{0, 0, 0, 0,  0,            0, 0, 0,  0,           0, 0, 0, 0,  0,            0, 32'hDEADBEEF, 1, 0};
        tab[5]  = '{0, 0, 0, 0,  0,            1, 1, 63, 32'h1234,    0, 1, 1, 63, 32'h1234,     0, 32'hDEADBEEF, 0, 0};
        tab[6]  = '{0, 1, 0, 63, 0,            0, 0, 0,  0,           1, 0, 0, 63, 0,            0, 32'hDEADBEEF, 0, 0};
        tab[7]  = '{0, 1, 0, 1,  0,            1, 0, 2,  0,           0, 1, 0, 2,  0,            1, 32'h1234,     0, 0};
        tab[8]  = '{0, 1, 0, 3,  0,            1, 0, 4,  0,           1, 0, 0, 3,  0,            0, 32'h1234,     1, 0};
        tab[9]  = '{0, 0, 0, 0,  0,            1, 1, 10, 32'hCAFE,    0, 1, 1, 10, 32'hCAFE,     1, 0,            0, 0};
        tab[10] = '{0, 0, 0, 0,  0,            1, 0, 10, 0,           0, 1, 0, 10, 0,            0, 0,            0, 0};
        tab[11] = '{0, 0, 0, 0,  0,            1, 0, 63, 0,           0, 1, 0, 63, 0,            0, 0,            1, 32'hCAFE};
        tab[12] = '{0, 0, 0, 0,  0,            0, 0, 0,  0,           0, 0, 0, 0,  0,            0, 0,            1, 32'h1234};
        tab[13] = '{0, 1, 0, 7,  0,            1, 0, 8,  0,           1, 0, 0, 7,  0,            0, 0,            0, 32'h1234};
        tab[14] = '{1, 0, 0, 0,  0,            0, 0, 0,  0,           0, 0, 0, 0,  0,            0, 0,            0, 0};
        tab[15] = '{0, 1, 0, 11, 0,            1, 0, 12, 0,           1, 0, 0, 11, 0,            0, 0,            0, 0};
        tab[16] = '{0, 1, 0, 11, 0,            1, 0, 12, 0,           0, 1, 0, 12, 0,            1, 0,            0, 0};
        tab[17] = '{0, 1, 0, 11, 0,            1, 0, 12, 0,           1, 0, 0, 11, 0,            0, 0,            1, 0};
        tab[18] = '{0, 1, 0, 11, 0,            1, 0, 12, 0,           0, 1, 0, 12, 0,            1, 0,            0, 0};
        tab[19] = '{0, 0, 0, 0,  0,            1, 0, 20, 0,           0, 1, 0, 20, 0,            0, 0,            1, 0};
        tab[20] = '{0, 0, 0, 0,  0,            1, 0, 21, 0,           0, 1, 0, 21, 0,            0, 0,            1, 0};
        tab[21] = '{0, 0, 0, 0,  0,            1, 0, 22, 0,           0, 1, 0, 22, 0,            0, 0,            1, 0};
        tab[22] = '{0, 0, 1, 30, 32'hFF,       0, 0, 0,  0,           0, 0, 0, 0,  0,            0, 0,            1, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

`ifdef RAMARB_CLEAR_EN
        // Reset in the middle of the clear walk restarts it from address 0.
        rst_cycle();
        clear_seq(20);
        rst_cycle();
        clear_seq(DEPTH);
`endif

        for (int i = 0; i < 23; i++) begin
            drive(tab[i].r[0], tab[i].av[0], tab[i].aw[0], tab[i].aa, tab[i].ad,
                  tab[i].bv[0], tab[i].bw[0], tab[i].ba, tab[i].bd);
            #4;
            chk($sformatf("row%0d a_ready", i), a_ready, tab[i].ear[0]);
            chk($sformatf("row%0d b_ready", i), b_ready, tab[i].ebr[0]);
            chk($sformatf("row%0d ram_we", i), ram_we, tab[i].ewe[0]);
            chk($sformatf("row%0d ram_addr", i), ram_addr, AW'(tab[i].eaddr));
            if (tab[i].ewe != 0) chk($sformatf("row%0d ram_din", i), ram_din, DW'(tab[i].edin));
            chk($sformatf("row%0d a_rvalid", i), a_rvalid, tab[i].earv[0]);
            chk($sformatf("row%0d a_rdata", i), a_rdata, DW'(tab[i].eard));
            chk($sformatf("row%0d b_rvalid", i), b_rvalid, tab[i].ebrv[0]);
            chk($sformatf("row%0d b_rdata", i), b_rdata, DW'(tab[i].ebrd));
            chk($sformatf("row%0d busy", i), busy, 1'b0);
            $display("[TB] row %0d rst=%0d a_ready=%0b b_ready=%0b we=%0b addr=%0d",
                     i, tab[i].r, a_ready, b_ready, ram_we, ram_addr);
            predict();
            finish_cycle();
`ifdef RAMARB_CLEAR_EN
            if (tab[i].r != 0) clear_seq(DEPTH);
`endif
        end

        // Randomized traffic on a narrow address window so reads hit recent writes.
        for (int n = 0; n < 250; n++) begin
            logic rr;
            rr = ($urandom_range(0, 59) == 0);
            drive(rr, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7) + (($urandom_range(0, 9) == 0) ? 56 : 0), $urandom);
            #4;
            check_model();
            $display("[TB] rnd %0d rst=%0b a_ready=%0b b_ready=%0b we=%0b addr=%0d",
                     n, rst, a_ready, b_ready, ram_we, ram_addr);
            finish_cycle();
`ifdef RAMARB_CLEAR_EN
            if (rr) clear_seq(DEPTH);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
